// File: rtl/e_tx_fifo_pkg.sv
// rtl/e_tx_fifo_pkg.sv - shared state encodings and block-size decode for the SDIO transmit buffer
package e_tx_fifo_pkg;

  typedef enum logic {
    ST_FILL  = 1'b0,
    ST_DRAIN = 1'b1
  } tx_state_e;

  localparam int TX_MAX_BLK = 512;

  // A zero or oversized block length falls back to the full buffer.
  function automatic logic [9:0] decode_bsz(input logic [11:0] raw);
    if (raw == 12'd0 || raw > 12'(TX_MAX_BLK)) return 10'(TX_MAX_BLK);
    return raw[9:0];
  endfunction

endpackage

// File: rtl/e_tx_fifo_ram.sv
// rtl/e_tx_fifo_ram.sv - byte register array with paired write ports and async read
module e_tx_fifo_ram #(
  parameter int DEPTH = 512,
  parameter int AW    = 9
) (
  input  logic          clk,
  input  logic [AW-1:0] wa,
  input  logic          we_lo,
  input  logic [7:0]    wd_lo,
  input  logic          we_hi,
  input  logic [7:0]    wd_hi,
  input  logic [AW-1:0] ra,
  output logic [7:0]    rd
);

  logic [7:0] mem [DEPTH];
  logic [AW-1:0] wa_next;

  assign wa_next = wa + 1'b1;

  always_ff @(posedge clk) begin
    if (we_lo) mem[wa] <= wd_lo;
    if (we_hi) mem[wa_next] <= wd_hi;
  end

  assign rd = mem[ra];

endmodule

// File: rtl/e_tx_fifo.sv
// rtl/e_tx_fifo.sv - fill-then-drain transmit block buffer between host and SD serializer
module e_tx_fifo
  import e_tx_fifo_pkg::*;
#(
  parameter int DEPTH = 512,
  parameter int AW    = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] block_size_reg,
  input  logic        blk_abort,
  input  logic        push,
  input  logic [15:0] push_data,
  input  logic        fifo_sel_l,
  input  logic        fifo_sel_h,
  output logic        buffer_write_en,
  input  logic        pop,
  output logic [7:0]  pop_data,
  output logic        buffer_read_rdy,
  output logic        tx_done
);

  tx_state_e     state_q, state_d;
  logic [AW:0]   wr_cnt, wr_next, bsz_q, bsz_dec, bsz_eff;
  logic [AW-1:0] rd_ptr;
  logic          is_fill, is_drain, both_sel, two_fit;
  logic          do_push, fill_done, last_pop;
  logic          we_hi;
  logic [7:0]    wd_lo, rd_byte;

  assign is_fill  = (state_q == ST_FILL);
  assign is_drain = (state_q == ST_DRAIN);
  assign bsz_dec  = (AW+1)'(decode_bsz(block_size_reg));

  // Until the first byte lands the live register decides the size, so a
  // push in the very first FILL cycle already sees the new block length.
  always_comb begin
    both_sel  = fifo_sel_l && fifo_sel_h;
    bsz_eff   = (wr_cnt == '0) ? bsz_dec : bsz_q;
    two_fit   = (wr_cnt + (AW+1)'(2)) <= bsz_eff;
    wr_next   = wr_cnt + ((both_sel && two_fit) ? (AW+1)'(2) : (AW+1)'(1));
    do_push   = is_fill && push && (fifo_sel_l || fifo_sel_h);
    fill_done = do_push && (wr_next == bsz_eff);
    last_pop  = is_drain && pop && ({1'b0, rd_ptr} == bsz_q - (AW+1)'(1));
    we_hi     = do_push && both_sel && two_fit;
    wd_lo     = fifo_sel_l ? push_data[7:0] : push_data[15:8];
  end

  e_tx_fifo_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .wa    (wr_cnt[AW-1:0]),
    .we_lo (do_push),
    .wd_lo (wd_lo),
    .we_hi (we_hi),
    .wd_hi (push_data[15:8]),
    .ra    (rd_ptr),
    .rd    (rd_byte)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_FILL;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (blk_abort)                  state_d = ST_FILL;
    else if (is_fill && fill_done)  state_d = ST_DRAIN;
    else if (is_drain && last_pop)  state_d = ST_FILL;
  end

  always_comb begin
    buffer_write_en = is_fill;
    buffer_read_rdy = is_drain;
    pop_data        = is_drain ? rd_byte : 8'h00;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt  <= '0;
      rd_ptr  <= '0;
      bsz_q   <= (AW+1)'(TX_MAX_BLK);
      tx_done <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (is_fill && wr_cnt == '0) bsz_q <= bsz_dec;
      if (blk_abort) begin
        wr_cnt <= '0;
        rd_ptr <= '0;
      end else if (is_fill) begin
        if (do_push)   wr_cnt <= wr_next;
        if (fill_done) rd_ptr <= '0;
      end else if (pop) begin
        if (last_pop) begin
          wr_cnt  <= '0;
          rd_ptr  <= '0;
          tx_done <= 1'b1;
        end else begin
          rd_ptr <= rd_ptr + 1'b1;
        end
      end
    end
  end

endmodule
